// File: rtl/spi_dma_rc_bst_var_if.sv
// Burst-read request and response bundle between the DMA command engine
// and the bus interface unit.
interface spi_dma_rc_bst_var_if #(
    parameter int AW = 32,
    parameter int BL = 4
) ();
    logic [AW-1:0] biu_adr;
    logic [BL:0]   biu_len;
    logic          biu_req;
    logic          biu_ack;
    logic          rsp_val;

    modport master (
        output biu_adr,
        output biu_len,
        output biu_req,
        input  biu_ack,
        input  rsp_val
    );

    modport slave (
        input  biu_adr,
        input  biu_len,
        input  biu_req,
        output biu_ack,
        output rsp_val
    );
endinterface

// File: rtl/spi_dma_rc_bst_var.sv
// Read-DMA command engine: variable-length bursts with FIFO credit, abort, error status.
// SPI_DMA_RC_ALIGN_EN: clamp each burst so it never crosses a 2**BL-word boundary.
module spi_dma_rc_bst_var #(
    parameter int AL = 2,
    parameter int AW = 32,
    parameter int BL = 4,
    parameter int FW = 6,
    parameter int LW = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pio_adr_we,
    input  logic        pio_len_we,
    input  logic        pio_abort,
    input  logic [31:0] pio_d,
    output logic [31:0] pio_adr,
    output logic [31:0] pio_len,
    output logic [31:0] pio_cst,
    input  logic [FW:0] dff_cnt,
    output logic        dff_ack,
    output logic        dff_eof,
    output logic        done,
    output logic        err,
    spi_dma_rc_bst_var_if.master biu
);
    localparam int AWW = AW - AL;
    localparam int LWW = LW - AL;
    localparam logic [BL:0]   MAXB    = {1'b1, {BL{1'b0}}};
    localparam logic [FW+1:0] FIFO_SZ = {2'b01, {FW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT
    } state_t;

    state_t         r_state;
    logic [AWW-1:0] r_adr;
    logic [LWW-1:0] r_len;
    logic [FW:0]    r_rsp_cnt;
    logic           r_abort;
    logic           r_err_st;
    logic           r_req;
    logic [AW-1:0]  r_biu_adr;
    logic [BL:0]    r_biu_len;

    logic [BL:0]    w_nxt_len;
    logic [FW+1:0]  w_sum;
    logic           w_req_ok;
    logic           w_ack;
    logic           w_take;
    logic           w_err;
    logic           w_last;
    logic [FW:0]    w_cnt_add;
    logic [FW:0]    w_cnt_sub;
    logic [LWW-1:0] w_pio_len_w;
    logic           w_unused;

    always_comb begin
        w_nxt_len = MAXB;
        if (32'(r_len) < 32'(MAXB))
            w_nxt_len = (BL+1)'(r_len);
`ifdef SPI_DMA_RC_ALIGN_EN
        if ((MAXB - {1'b0, r_adr[BL-1:0]}) < w_nxt_len)
            w_nxt_len = MAXB - {1'b0, r_adr[BL-1:0]};
`endif
    end

    // Words in flight plus words already buffered must leave room for the burst.
    assign w_sum = (FW+2)'(r_rsp_cnt) + (FW+2)'(dff_cnt)
                 + (FW+2)'(w_nxt_len);
    assign w_req_ok = (w_sum <= FIFO_SZ);

    assign w_ack  = r_req & biu.biu_ack;
    assign w_take = biu.rsp_val & (r_rsp_cnt != '0);
    assign w_err  = biu.rsp_val & (r_rsp_cnt == '0);
    assign w_last = biu.rsp_val & (r_rsp_cnt == (FW+1)'(1))
                  & ((r_len == '0) | r_abort) & ~r_req;

    assign w_cnt_add = w_ack ? (FW+1)'(r_biu_len) : '0;
    assign w_cnt_sub = (FW+1)'(w_take);
    assign w_pio_len_w = pio_d[LW-1:AL];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_adr     <= '0;
            r_len     <= '0;
            r_rsp_cnt <= '0;
            r_abort   <= 1'b0;
            r_err_st  <= 1'b0;
            r_req     <= 1'b0;
            r_biu_adr <= '0;
            r_biu_len <= '0;
        end else begin
            r_rsp_cnt <= r_rsp_cnt + w_cnt_add - w_cnt_sub;
            if (w_err)
                r_err_st <= 1'b1;
            if (w_ack) begin
                r_req <= 1'b0;
                r_adr <= r_adr + AWW'(r_biu_len);
                r_len <= r_len - LWW'(r_biu_len);
            end
            unique case (r_state)
                S_IDLE: begin
                    r_abort <= 1'b0;
                    if (pio_adr_we)
                        r_adr <= pio_d[AW-1:AL];
                    if (pio_len_we) begin
                        r_len    <= w_pio_len_w;
                        r_err_st <= 1'b0;
                        if (w_pio_len_w != '0)
                            r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (pio_abort)
                        r_abort <= 1'b1;
                    if (!r_req && r_len != '0 && w_req_ok && !r_abort) begin
                        r_req     <= 1'b1;
                        r_biu_adr <= {r_adr, {AL{1'b0}}};
                        r_biu_len <= w_nxt_len;
                    end
                    if (r_len == '0 || (r_abort && !r_req))
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (pio_abort)
                        r_abort <= 1'b1;
                    if (r_rsp_cnt == '0)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign biu.biu_adr = r_biu_adr;
    assign biu.biu_len = r_biu_len;
    assign biu.biu_req = r_req;

    assign dff_ack = biu.rsp_val;
    assign dff_eof = ~rst & w_last;
    assign done    = ~rst & w_last;
    assign err     = ~rst & w_err;

    assign pio_adr = 32'({r_adr, {AL{1'b0}}});
    assign pio_len = 32'({r_len, {AL{1'b0}}});

    always_comb begin
        pio_cst          = '0;
        pio_cst[FW:0]    = r_rsp_cnt;
        pio_cst[16+FW:16] = dff_cnt;
        pio_cst[29]      = r_abort;
        pio_cst[30]      = r_err_st;
        pio_cst[31]      = (r_state != S_IDLE);
    end

    assign w_unused = ^{pio_d[AL-1:0]};
endmodule

// File: tb/tb_spi_dma_rc_bst_var.sv
// Randomized bench for spi_dma_rc_bst_var: BIU/response model plus
// a burst-list reference computed from the transfer rules.
module tb_spi_dma_rc_bst_var;
    localparam int AL = 2;
    localparam int AW = 32;
    localparam int BL = 4;
    localparam int FW = 6;
    localparam int LW = 24;
    localparam int MAXB = 1 << BL;
    localparam int FSZ = 1 << FW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pio_adr_we = 1'b0;
    logic        pio_len_we = 1'b0;
    logic        pio_abort = 1'b0;
    logic [31:0] pio_d = '0;
    logic [31:0] pio_adr;
    logic [31:0] pio_len;
    logic [31:0] pio_cst;
    logic [FW:0] dff_cnt = '0;
    logic        dff_ack;
    logic        dff_eof;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    spi_dma_rc_bst_var_if #(.AW(AW), .BL(BL)) biu ();

    spi_dma_rc_bst_var #(
        .AL(AL), .AW(AW), .BL(BL), .FW(FW), .LW(LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pio_adr_we (pio_adr_we),
        .pio_len_we (pio_len_we),
        .pio_abort  (pio_abort),
        .pio_d      (pio_d),
        .pio_adr    (pio_adr),
        .pio_len    (pio_len),
        .pio_cst    (pio_cst),
        .dff_cnt    (dff_cnt),
        .dff_ack    (dff_ack),
        .dff_eof    (dff_eof),
        .done       (done),
        .err        (err),
        .biu        (biu.master)
    );

    int checks = 0;
    int errors = 0;

    bit rsp_en = 1'b0;
    bit ack_hold = 1'b0;
    bit force_rsp = 1'b0;
    int abort_at = 0;
    int ack_dly = 0;
    int rsp_pct = 100;
    int req_age = 0;
    int outst = 0;
    int words = 0;
    int done_cnt = 0;
    int eof_cnt = 0;
    int err_cnt = 0;
    int done_word = 0;
    int eof_word = 0;
    int peak = 0;
    logic [31:0] q_adr[$];
    int          q_len[$];

    // Bus model: responses use only words owed before this cycle's ack.
    initial begin
        biu.biu_ack = 1'b0;
        biu.rsp_val = 1'b0;
        forever begin
            @(negedge clk);
            if (int'(pio_cst[FW:0]) > peak)
                peak = int'(pio_cst[FW:0]);
            pio_abort = 1'b0;
            biu.rsp_val = 1'b0;
            if (force_rsp) begin
                biu.rsp_val = 1'b1;
                force_rsp = 1'b0;
            end else if (rsp_en && outst > 0
                         && $urandom_range(99) < rsp_pct) begin
                biu.rsp_val = 1'b1;
                outst--;
                words++;
            end
            biu.biu_ack = 1'b0;
            if (biu.biu_req && !rst) begin
                if (!ack_hold && req_age >= ack_dly) begin
                    biu.biu_ack = 1'b1;
                    q_adr.push_back(biu.biu_adr);
                    q_len.push_back(int'(biu.biu_len));
                    outst += int'(biu.biu_len);
                    req_age = 0;
                    if (abort_at == q_adr.size())
                        pio_abort = 1'b1;
                end else begin
                    req_age++;
                end
            end else begin
                req_age = 0;
            end
            #1;
            if (done) begin
                done_cnt++;
                done_word = words;
            end
            if (dff_eof) begin
                eof_cnt++;
                eof_word = words;
            end
            if (err)
                err_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        q_adr.delete();
        q_len.delete();
        done_cnt = 0;
        eof_cnt = 0;
        err_cnt = 0;
        done_word = 0;
        eof_word = 0;
        words = 0;
        peak = 0;
        outst = 0;
    endtask

    task automatic pio_wr(input bit is_len, input logic [31:0] d);
        @(negedge clk);
        pio_d = d;
        if (is_len) pio_len_we = 1'b1;
        else        pio_adr_we = 1'b1;
        @(negedge clk);
        pio_adr_we = 1'b0;
        pio_len_we = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (pio_cst[31] && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pio_cst[31] !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0",
                     nm, pio_cst[31], n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_xfer(input logic [31:0] a, input int nw);
        clear_obs();
        pio_wr(1'b0, a);
        pio_wr(1'b1, 32'(nw) << AL);
    endtask

    task automatic check_bursts(input string nm, input logic [31:0] a,
                                input int nw);
        logic [31:0] ea[$];
        int el[$];
        int rem;
        int wa;
        int n;
        rem = nw;
        wa = int'(a >> AL);
        while (rem > 0) begin
            n = (rem < MAXB) ? rem : MAXB;
`ifdef SPI_DMA_RC_ALIGN_EN
            if (MAXB - (wa % MAXB) < n)
                n = MAXB - (wa % MAXB);
`endif
            ea.push_back(32'(wa) << AL);
            el.push_back(n);
            wa += n;
            rem -= n;
        end
        checks++;
        if (q_adr.size() != ea.size()) begin
            errors++;
            $display("FAIL %s_nbursts: got %0d, want %0d",
                     nm, q_adr.size(), ea.size());
        end else begin
            foreach (ea[i]) begin
                checks++;
                if (q_adr[i] !== ea[i] || q_len[i] != el[i]) begin
                    errors++;
                    $display("FAIL %s_burst%0d: got adr=%h len=%0d, want adr=%h len=%0d",
                             nm, i, q_adr[i], q_len[i], ea[i], el[i]);
                end
            end
        end
    endtask

    task automatic check_end(input string nm, input logic [31:0] a,
                             input int nw);
        logic [31:0] ea;
        ea = a + (32'(nw) << AL);
        checks++;
        if (done_cnt != 1 || done_word != nw) begin
            errors++;
            $display("FAIL %s_done: got pulses=%0d at word %0d, want 1 at %0d",
                     nm, done_cnt, done_word, nw);
        end
        checks++;
        if (eof_cnt != 1 || eof_word != nw) begin
            errors++;
            $display("FAIL %s_eof: got pulses=%0d at word %0d, want 1 at %0d",
                     nm, eof_cnt, eof_word, nw);
        end
        checks++;
        if (pio_len !== 32'h0 || pio_adr !== ea) begin
            errors++;
            $display("FAIL %s_regs: got len=%h adr=%h, want len=0 adr=%h",
                     nm, pio_len, pio_adr, ea);
        end
        checks++;
        if (err_cnt != 0 || words != nw) begin
            errors++;
            $display("FAIL %s_count: got err=%0d words=%0d, want 0 and %0d",
                     nm, err_cnt, words, nw);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pio_cst !== 32'h0) begin
            errors++;
            $display("FAIL reset_cst: got %h, want 0", pio_cst);
        end
        checks++;
        if (pio_adr !== 32'h0 || pio_len !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: got adr=%h len=%h, want 0 0",
                     pio_adr, pio_len);
        end
        checks++;
        if ({biu.biu_req, done, err, dff_eof} !== 4'b0) begin
            errors++;
            $display("FAIL reset_outs: got req/done/err/eof=%b, want 0000",
                     {biu.biu_req, done, err, dff_eof});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pio_cst[31] !== 1'b0 || biu.biu_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b req=%b, want 0 0",
                     pio_cst[31], biu.biu_req);
        end
    endtask

    task automatic test_aligned();
        rsp_en = 1'b1;
        rsp_pct = 100;
        ack_dly = 0;
        dff_cnt = '0;
        run_xfer(32'h1000, 64);
        wait_idle("aligned");
        check_bursts("aligned", 32'h1000, 64);
        check_end("aligned", 32'h1000, 64);
    endtask

    task automatic test_tail();
        rsp_pct = 50;
        ack_dly = 1;
        run_xfer(32'h4000, 19);
        wait_idle("tail");
        check_bursts("tail", 32'h4000, 19);
        check_end("tail", 32'h4000, 19);
        checks++;
        if (peak > 19 || peak == 0) begin
            errors++;
            $display("FAIL tail_peak: got rsp_cnt peak %0d, want 1..19", peak);
        end
    endtask

    task automatic test_credit_stall();
        rsp_en = 1'b1;
        rsp_pct = 100;
        ack_dly = 0;
        ack_hold = 1'b1;
        dff_cnt = 7'd56;
        run_xfer(32'h2000, 16);
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (biu.biu_req !== 1'b0) begin
                errors++;
                $display("FAIL credit_stall: got req=%b, want 0", biu.biu_req);
            end
        end
        dff_cnt = 7'd48;
        @(negedge clk);
        checks++;
        if (biu.biu_req !== 1'b1) begin
            errors++;
            $display("FAIL credit_release: got req=%b, want 1", biu.biu_req);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (biu.biu_req !== 1'b1 || biu.biu_adr !== 32'h2000
                || biu.biu_len !== 5'd16) begin
                errors++;
                $display("FAIL credit_hold: got req=%b adr=%h len=%0d, want 1 2000 16",
                         biu.biu_req, biu.biu_adr, biu.biu_len);
            end
        end
        ack_hold = 1'b0;
        wait_idle("credit");
        dff_cnt = '0;
        check_bursts("credit", 32'h2000, 16);
        check_end("credit", 32'h2000, 16);
    endtask

    task automatic test_abort();
        int n;
        rsp_en = 1'b0;
        ack_dly = 1;
        abort_at = 2;
        run_xfer(32'h3000, 64);
        n = 0;
        while (q_adr.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        checks++;
        if (q_adr.size() != 2 || biu.biu_req !== 1'b0) begin
            errors++;
            $display("FAIL abort_issue: got bursts=%0d req=%b, want 2 0",
                     q_adr.size(), biu.biu_req);
        end
        checks++;
        if (pio_cst[31] !== 1'b1 || pio_cst[29] !== 1'b1
            || pio_cst[FW:0] !== 7'd32) begin
            errors++;
            $display("FAIL abort_cst: got %h, want busy,abort set and rsp_cnt 32",
                     pio_cst);
        end
        checks++;
        if (pio_len !== 32'h80) begin
            errors++;
            $display("FAIL abort_len: got %h, want 80", pio_len);
        end
        abort_at = 0;
        rsp_pct = 70;
        rsp_en = 1'b1;
        wait_idle("abort");
        checks++;
        if (q_adr.size() != 2 || done_cnt != 1 || done_word != 32) begin
            errors++;
            $display("FAIL abort_drain: got bursts=%0d done=%0d at word %0d, want 2 1 32",
                     q_adr.size(), done_cnt, done_word);
        end
        checks++;
        if (pio_len !== 32'h80 || pio_adr !== 32'h3080 || pio_cst[29] !== 1'b0
            || err_cnt != 0) begin
            errors++;
            $display("FAIL abort_final: got len=%h adr=%h cst=%h err=%0d, want 80 3080 abort clear 0",
                     pio_len, pio_adr, pio_cst, err_cnt);
        end
    endtask

    task automatic test_error();
        clear_obs();
        force_rsp = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (err_cnt != 1) begin
            errors++;
            $display("FAIL error_pulse: got %0d pulses, want 1", err_cnt);
        end
        checks++;
        if (pio_cst[30] !== 1'b1 || pio_cst[FW:0] !== 7'd0) begin
            errors++;
            $display("FAIL error_sticky: got cst=%h, want bit30 set, rsp_cnt 0",
                     pio_cst);
        end
        pio_wr(1'b1, 32'h0);
        @(negedge clk);
        checks++;
        if (pio_cst[30] !== 1'b0 || pio_cst[31] !== 1'b0) begin
            errors++;
            $display("FAIL error_clear: got cst=%h, want err and busy clear",
                     pio_cst);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        rsp_en = 1'b0;
        ack_dly = 0;
        run_xfer(32'h5000, 64);
        n = 0;
        while (q_adr.size() < 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        outst = 0;
        @(negedge clk);
        checks++;
        if (pio_cst !== 32'h0 || biu.biu_req !== 1'b0
            || pio_len !== 32'h0 || pio_adr !== 32'h0) begin
            errors++;
            $display("FAIL midreset_state: got cst=%h req=%b len=%h adr=%h, want all 0",
                     pio_cst, biu.biu_req, pio_len, pio_adr);
        end
        err_cnt = 0;
        force_rsp = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (err_cnt != 1 || pio_cst[30] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_late: got err=%0d sticky=%b, want 1 1",
                     err_cnt, pio_cst[30]);
        end
        pio_wr(1'b1, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int nw;
        int dff;
        rsp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = 32'h8000 + (32'($urandom_range(0, 255)) << AL);
            nw = $urandom_range(1, 100);
            rsp_pct = $urandom_range(20, 100);
            ack_dly = $urandom_range(0, 3);
            dff = $urandom_range(0, 48);
            dff_cnt = 7'(dff);
            run_xfer(a, nw);
            wait_idle($sformatf("rand%0d", i));
            check_bursts($sformatf("rand%0d", i), a, nw);
            check_end($sformatf("rand%0d", i), a, nw);
            checks++;
            if (peak + dff > FSZ) begin
                errors++;
                $display("FAIL rand%0d_credit: got rsp_cnt peak %0d + fifo %0d, want <= %0d",
                         i, peak, dff, FSZ);
            end
        end
        dff_cnt = '0;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_tail();
        test_credit_stall();
        test_abort();
        test_error();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_dma_rc_bst_var.md
Name: spi_dma_rc_bst_var

Overview:
- Next-generation read-DMA command engine for the SPI DMA read path.
- Issues Avalon-style burst read requests to the bus interface unit and tracks outstanding response words against free space in the downstream data FIFO.
- Burst length is variable per request, so transfer length is word-granular rather than burst-granular. The final partial burst is issued with a shortened length.
- Adds abort, a busy/error status word, and sticky error reporting.

Parameters:
- AL, 2: address LSB; data word = 2**AL bytes; address/length bits [AL-1:0] ignored.
- AW, 32: bus address width.
- BL, 4: max burst = 2**BL words; BL>0.
- FW, 6: FIFO level width; FIFO size = 2**FW words; FW>=BL.
- LW, 24: transfer length register width in bytes; LW>AL.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset, whole block
- pio_adr_we  in  1  load start address from pio_d
- pio_len_we  in  1  load byte length from pio_d; nonzero starts transfer
- pio_abort  in  1  stop issuing new bursts
- pio_d  in  32  PIO write data
- pio_adr  out  32  current address (byte, AL lsbs zero)
- pio_len  out  32  remaining length (bytes)
- pio_cst  out  32  status word
- dff_cnt  in  FW+1  words currently in data FIFO
- dff_ack  out  1  FIFO write strobe (=rsp_val)
- dff_eof  out  1  marks last word of transfer
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse
- biu_adr  out  AW  burst start address
- biu_len  out  BL+1  burst length in words, 1..2**BL
- biu_req  out  1  burst request
- biu_ack  in  1  burst accepted
- rsp_val  in  1  read data word valid

Behaviour:
- Reset: state=IDLE; adr, len, rsp_cnt, err_sticky = 0; biu_req, done, err, dff_eof = 0.
- Registers are held in words: adr_w = address[AW-1:AL], len_w = length[LW-1:AL].
- pio_adr_we / pio_len_we are ignored unless state==IDLE.
- States:
  - IDLE: pio_len_we with nonzero word length → RUN.
  - RUN: issues bursts. Goes to WAIT when len_w==0, or when abort is latched and no request is pending.
  - WAIT: no new requests. When rsp_cnt==0 → IDLE. done pulses on the cycle the last response is taken.
- nxt_len = min(2**BL, len_w).
- Credit: req_ok = (rsp_cnt + dff_cnt + nxt_len) <= 2**FW. Sums are computed at FW+2 bits; no wrap.
- biu_req is registered:
  - Set in RUN when !biu_req, len_w!=0, req_ok and no abort latched.
  - biu_adr/biu_len are captured at the same edge and held stable until biu_ack.
  - Cleared on the cycle after biu_ack.
  - Minimum one idle cycle between bursts.
- On biu_ack: adr_w += biu_len; len_w -= biu_len; rsp_cnt += biu_len.
- On rsp_val: rsp_cnt -= 1.
- Simultaneous biu_ack and rsp_val: rsp_cnt += biu_len-1.
- pio_abort: latched. A pending request still completes on its ack. Outstanding responses are drained in WAIT; pio_len then reports the unissued remainder. The latch clears on IDLE.
- dff_eof = rsp_val & rsp_cnt==1 & len_w==0 & !biu_req. done equals the same term. Under abort the len_w==0 term is dropped.
- err pulses when rsp_val & rsp_cnt==0; the response is not counted and rsp_cnt stays 0. err_sticky is set and cleared only by reset or by pio_len_we in IDLE.
- pio_cst layout:
  - [FW:0] = rsp_cnt
  - [16+FW:16] = dff_cnt
  - [29] = abort latched
  - [30] = err_sticky
  - [31] = busy (state!=IDLE)
- Reset mid-transfer: immediate return to IDLE with all counts cleared; late responses after reset raise err.

Optional Feature:
- Macro: SPI_DMA_RC_ALIGN_EN.
- Defined: nxt_len additionally clamps to the words remaining to the next 2**BL-word boundary (2**BL - adr_w[BL-1:0]). Every burst after the first is aligned and never crosses a max-burst boundary.
- Undefined: no alignment clamp; bursts start at any word address.

Test Plan:
- Aligned run: BL=4, FW=6, adr 0x1000, len 0x100 (64 words), FIFO drained instantly → 4 bursts of 16 at 0x1000/0x1040/0x1080/0x10C0; one done pulse; dff_eof on word 64; pio_len=0.
- Partial tail: len 0x4C (19 words) → bursts 16 then 3; rsp_cnt peaks ≤19; done after word 19.
- Credit stall: dff_cnt held at 56, rsp_cnt 0, nxt_len 16 → biu_req stays low. Dropping dff_cnt to 48 → req on the next edge. Hold biu_ack low 5 cycles → biu_adr/biu_len stable.
- Abort: assert pio_abort after the 2nd ack of 64-word transfer → no 3rd request; 32 responses drain; done pulses; pio_len=0x80; pio_cst[29]=1; return to IDLE.
- Error: rsp_val with rsp_cnt==0 in IDLE → err pulse, pio_cst[30]=1, rsp_cnt stays 0. pio_len_we clears it.
- ALIGN_EN: adr 0x1008 (word 2), len 64 words → bursts 14,16,16,16,2; undefined → 16,16,16,16.
